// File: rtl/fsb_node_trace_replay_if.sv
`default_nettype none
// ============================================================================
// Module  : fsb_node_trace_replay_if
// Purpose : Bundles the trace-replay engine's stimulus, response, ROM and
//           status signals.
//           master = replay engine, slave = DUT/ROM/bench side.
// Signals : en_i        run enable (1 = run, 0 = stall)
//           v_o/data_o/yumi_i     stimulus port (valid/yumi)
//           v_i/data_i/ready_o    response port (valid/ready)
//           rom_addr_o/rom_data_i zero-latency ROM lookup
//           done_o/error_o        sticky status
// Revision: 1.0 - initial release
// ============================================================================
interface fsb_node_trace_replay_if #(
    parameter int ring_width_p     = 80,
    parameter int rom_addr_width_p = 6
);
    logic                          en_i;
    logic                          v_i;
    logic [ring_width_p-1:0]       data_i;
    logic                          ready_o;
    logic                          v_o;
    logic [ring_width_p-1:0]       data_o;
    logic                          yumi_i;
    logic [rom_addr_width_p-1:0]   rom_addr_o;
    logic [ring_width_p+3:0]       rom_data_i;
    logic                          done_o;
    logic                          error_o;

    modport master (
        input  en_i, v_i, data_i, yumi_i, rom_data_i,
        output ready_o, v_o, data_o, rom_addr_o, done_o, error_o
    );

    modport slave (
        output en_i, v_i, data_i, yumi_i, rom_data_i,
        input  ready_o, v_o, data_o, rom_addr_o, done_o, error_o
    );
endinterface
`default_nettype wire

// File: rtl/fsb_node_trace_replay.sv
`default_nettype none
// ============================================================================
// Module  : fsb_node_trace_replay
// Purpose : Trace-replay engine. Steps through an external combinational ROM
//           of {op[3:0], payload} words, sending payloads over a valid/yumi
//           port, checking responses on a valid/ready port, and flagging
//           completion (done_o) and mismatches/illegal ops (error_o).
// Ports   : clk_i      clock, all state updates on rising edge
//           reset_n_i  asynchronous active-low reset
//           bus        fsb_node_trace_replay_if.master (see interface header)
// Revision: 1.0 - initial release
// ============================================================================
module fsb_node_trace_replay #(
    parameter int ring_width_p     = 80,
    parameter int rom_addr_width_p = 6,
    parameter int counter_width_p  = 32
) (
    input  wire logic clk_i,
    input  wire logic reset_n_i,
    fsb_node_trace_replay_if.master bus
);

    localparam logic [3:0] c_op_nop    = 4'd0;
    localparam logic [3:0] c_op_send   = 4'd1;
    localparam logic [3:0] c_op_recv   = 4'd2;
    localparam logic [3:0] c_op_done   = 4'd3;
    localparam logic [3:0] c_op_finish = 4'd4;
    localparam logic [3:0] c_op_wait   = 4'd5;
    localparam logic [3:0] c_op_load   = 4'd6;

    localparam logic [rom_addr_width_p-1:0] c_addr_one = 1;
    localparam logic [counter_width_p-1:0]  c_cnt_one  = 1;

    logic [rom_addr_width_p-1:0] r_addr;
    logic                        r_done;
    logic                        r_error;
    logic [counter_width_p-1:0]  r_cnt;

    logic [3:0]                  w_op;
    logic [ring_width_p-1:0]     w_payload;
    logic                        w_active;
    logic                        w_advance;
    logic                        w_set_error;
    logic                        w_set_done;
    logic                        w_load;
    logic                        w_dec;
    logic                        w_v;
    logic                        w_ready;

    assign w_op      = bus.rom_data_i[ring_width_p+3:ring_width_p];
    assign w_payload = bus.rom_data_i[ring_width_p-1:0];

    // Gating with reset_n_i keeps v_o/ready_o low while reset is held, even
    // though the cleared state would otherwise present word 0 as active.
    assign w_active = bus.en_i & ~r_done & reset_n_i;

    always_comb begin
        w_advance   = 1'b0;
        w_set_error = 1'b0;
        w_set_done  = 1'b0;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        w_v         = 1'b0;
        w_ready     = 1'b0;
        if (w_active) begin
            case (w_op)
                c_op_nop: begin
                    w_advance = 1'b1;
                end
                c_op_send: begin
                    // v_o is driven purely by the opcode; yumi_i only retires.
                    w_v       = 1'b1;
                    w_advance = bus.yumi_i;
                end
                c_op_recv: begin
                    w_ready = 1'b1;
                    if (bus.v_i) begin
                        w_advance = 1'b1;
                        if (bus.data_i != w_payload) begin
                            w_set_error = 1'b1;
                        end
                    end
                end
                c_op_done, c_op_finish: begin
                    w_set_done = 1'b1;
                end
                c_op_wait: begin
                    if (r_cnt == '0) begin
                        w_advance = 1'b1;
                    end else begin
                        w_dec = 1'b1;
                    end
                end
                c_op_load: begin
                    w_load    = 1'b1;
                    w_advance = 1'b1;
                end
                default: begin
                    // Unknown opcodes flag an error and otherwise behave as NOP.
                    w_set_error = 1'b1;
                    w_advance   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_addr  <= '0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_advance) begin
                r_addr <= r_addr + c_addr_one;
            end
            if (w_set_done) begin
                r_done <= 1'b1;
            end
            if (w_set_error) begin
                r_error <= 1'b1;
            end
            if (w_load) begin
                r_cnt <= w_payload[counter_width_p-1:0];
            end else if (w_dec) begin
                r_cnt <= r_cnt - c_cnt_one;
            end
        end
    end

    assign bus.rom_addr_o = r_addr;
    assign bus.data_o     = w_payload;
    assign bus.v_o        = w_v;
    assign bus.ready_o    = w_ready;
    assign bus.done_o     = r_done;
    assign bus.error_o    = r_error;

endmodule
`default_nettype wire

// File: tb/tb_fsb_node_trace_replay.sv
`default_nettype none
// ============================================================================
// Module  : tb_fsb_node_trace_replay
// Purpose : Directed self-checking bench for fsb_node_trace_replay. Each task
//           loads a small trace into the bench ROM, resets the engine and
//           checks addresses, handshakes and status against hand-computed
//           values.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fsb_node_trace_replay;

    localparam int RW = 80;
    localparam int AW = 6;

    logic clk_i;
    logic reset_n_i;

    int n_cmp;
    int n_fail;

    logic [RW+3:0] rom [64];

    fsb_node_trace_replay_if #(.ring_width_p(RW), .rom_addr_width_p(AW)) bus ();

    fsb_node_trace_replay #(
        .ring_width_p    (RW),
        .rom_addr_width_p(AW),
        .counter_width_p (32)
    ) u_dut (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .bus      (bus)
    );

    assign bus.rom_data_i = rom[bus.rom_addr_o];

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [RW+3:0] mk(input logic [3:0] op, input logic [RW-1:0] p);
        return {op, p};
    endfunction

    // Fill the whole ROM with DONE so a runaway address halts quickly.
    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = mk(4'd3, '0);
    endtask

    // Reset is asserted and released away from the rising edge; returns
    // mid-cycle with word 0 presented.
    task automatic apply_reset();
        @(negedge clk_i);
        reset_n_i = 1'b0;
        #2;
        reset_n_i = 1'b1;
        #1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        logic [RW-1:0] p;
        p = 80'h1111_2222_3333_4444_5501;
        clear_rom();
        rom[0] = mk(4'd1, p);
        bus.en_i = 1'b1;
        @(negedge clk_i);
        reset_n_i = 1'b0;
        #1;
        n_cmp++; if (bus.v_o !== 1'b0) begin n_fail++; $display("FAIL reset_v_o: got %b want 0", bus.v_o); end
        n_cmp++; if (bus.ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready_o: got %b want 0", bus.ready_o); end
        n_cmp++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done_o: got %b want 0", bus.done_o); end
        n_cmp++; if (bus.error_o !== 1'b0) begin n_fail++; $display("FAIL reset_error_o: got %b want 0", bus.error_o); end
        n_cmp++; if (bus.rom_addr_o !== 6'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", bus.rom_addr_o); end
        reset_n_i = 1'b1;
        #1;
        n_cmp++; if (bus.v_o !== 1'b1) begin n_fail++; $display("FAIL post_reset_v_o: got %b want 1", bus.v_o); end
        n_cmp++; if (bus.data_o !== p) begin n_fail++; $display("FAIL post_reset_data_o: got %h want %h", bus.data_o, p); end
    endtask

    task automatic test_loopback();
        logic [RW-1:0] a;
        logic [RW-1:0] fifo;
        a = 80'hA5A5_0000_0000_0000_0001;
        clear_rom();
        rom[0] = mk(4'd1, a);
        rom[1] = mk(4'd2, a);
        rom[2] = mk(4'd3, '0);
        apply_reset();
        n_cmp++; if (bus.v_o !== 1'b1 || bus.ready_o !== 1'b0) begin n_fail++; $display("FAIL lb_send_valid: got v=%b r=%b want v=1 r=0", bus.v_o, bus.ready_o); end
        fifo = bus.data_o;
        bus.yumi_i = 1'b1;
        tick();
        bus.yumi_i = 1'b0;
        #1;
        n_cmp++; if (bus.rom_addr_o !== 6'd1) begin n_fail++; $display("FAIL lb_addr1: got %0d want 1", bus.rom_addr_o); end
        n_cmp++; if (bus.ready_o !== 1'b1 || bus.v_o !== 1'b0) begin n_fail++; $display("FAIL lb_recv_ready: got r=%b v=%b want r=1 v=0", bus.ready_o, bus.v_o); end
        bus.v_i    = 1'b1;
        bus.data_i = fifo;
        tick();
        bus.v_i = 1'b0;
        #1;
        n_cmp++; if (bus.rom_addr_o !== 6'd2) begin n_fail++; $display("FAIL lb_addr2: got %0d want 2", bus.rom_addr_o); end
        n_cmp++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL lb_done_early: got %b want 0", bus.done_o); end
        tick();
        n_cmp++; if (bus.done_o !== 1'b1) begin n_fail++; $display("FAIL lb_done: got %b want 1", bus.done_o); end
        n_cmp++; if (bus.error_o !== 1'b0) begin n_fail++; $display("FAIL lb_error: got %b want 0", bus.error_o); end
        n_cmp++; if (bus.rom_addr_o !== 6'd2) begin n_fail++; $display("FAIL lb_addr_hold: got %0d want 2", bus.rom_addr_o); end
        tick();
        n_cmp++; if (bus.done_o !== 1'b1 || bus.v_o !== 1'b0 || bus.ready_o !== 1'b0) begin n_fail++; $display("FAIL lb_done_sticky: got d=%b v=%b r=%b want 1 0 0", bus.done_o, bus.v_o, bus.ready_o); end
    endtask

    task automatic test_mismatch();
        clear_rom();
        rom[0] = mk(4'd2, 80'h5);
        rom[1] = mk(4'd3, '0);
        apply_reset();
        bus.v_i    = 1'b1;
        bus.data_i = 80'h6;
        tick();
        bus.v_i = 1'b0;
        #1;
        n_cmp++; if (bus.error_o !== 1'b1) begin n_fail++; $display("FAIL mm_error: got %b want 1", bus.error_o); end
        n_cmp++; if (bus.rom_addr_o !== 6'd1) begin n_fail++; $display("FAIL mm_addr: got %0d want 1", bus.rom_addr_o); end
        tick();
        tick();
        n_cmp++; if (bus.error_o !== 1'b1 || bus.done_o !== 1'b1) begin n_fail++; $display("FAIL mm_sticky: got e=%b d=%b want 1 1", bus.error_o, bus.done_o); end
        // A difference only in the top payload bit must still be caught.
        clear_rom();
        rom[0] = mk(4'd2, 80'h8000_0000_0000_0000_0000);
        apply_reset();
        bus.v_i    = 1'b1;
        bus.data_i = '0;
        tick();
        bus.v_i = 1'b0;
        #1;
        n_cmp++; if (bus.error_o !== 1'b1) begin n_fail++; $display("FAIL mm_msb_error: got %b want 1", bus.error_o); end
        // Matching response: no error; v_i while ready_o=0 ignored afterwards.
        clear_rom();
        rom[0] = mk(4'd2, 80'h8000_0000_0000_0000_0000);
        apply_reset();
        bus.v_i    = 1'b1;
        bus.data_i = 80'h8000_0000_0000_0000_0000;
        tick();
        bus.data_i = 80'h1;
        tick();
        bus.v_i = 1'b0;
        #1;
        n_cmp++; if (bus.error_o !== 1'b0 || bus.rom_addr_o !== 6'd1) begin n_fail++; $display("FAIL mm_match: got e=%b a=%0d want e=0 a=1", bus.error_o, bus.rom_addr_o); end
    endtask

    task automatic test_send_stall();
        logic [RW-1:0] b;
        b = 80'hDEAD_BEEF_0123_4567_89AB;
        clear_rom();
        rom[0] = mk(4'd1, b);
        apply_reset();
        bus.yumi_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (bus.v_o !== 1'b1 || bus.rom_addr_o !== 6'd0 || bus.data_o !== b) begin
                n_fail++; $display("FAIL stall_%0d: got v=%b a=%0d d=%h want v=1 a=0 d=%h", i, bus.v_o, bus.rom_addr_o, bus.data_o, b);
            end
        end
        bus.yumi_i = 1'b1;
        tick();
        bus.yumi_i = 1'b0;
        #1;
        n_cmp++; if (bus.rom_addr_o !== 6'd1) begin n_fail++; $display("FAIL stall_release_addr: got %0d want 1", bus.rom_addr_o); end
    endtask

    task automatic test_wait();
        clear_rom();
        rom[0] = mk(4'd6, 80'h3);
        rom[1] = mk(4'd5, '0);
        rom[2] = mk(4'd3, '0);
        apply_reset();
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (bus.rom_addr_o !== 6'd1 || bus.done_o !== 1'b0) begin
                n_fail++; $display("FAIL wait_hold_%0d: got a=%0d d=%b want a=1 d=0", i, bus.rom_addr_o, bus.done_o);
            end
        end
        tick();
        n_cmp++; if (bus.rom_addr_o !== 6'd2 || bus.done_o !== 1'b0) begin n_fail++; $display("FAIL wait_exit: got a=%0d d=%b want a=2 d=0", bus.rom_addr_o, bus.done_o); end
        tick();
        n_cmp++; if (bus.done_o !== 1'b1) begin n_fail++; $display("FAIL wait_done: got %b want 1", bus.done_o); end
    endtask

    task automatic test_enable();
        logic [RW-1:0] c;
        c = 80'h0C0C_0C0C_0C0C_0C0C_0C0C;
        clear_rom();
        rom[0] = mk(4'd1, c);
        apply_reset();
        bus.en_i   = 1'b0;
        bus.yumi_i = 1'b1;
        #1;
        n_cmp++; if (bus.v_o !== 1'b0) begin n_fail++; $display("FAIL en_off_v_o: got %b want 0", bus.v_o); end
        tick();
        tick();
        n_cmp++; if (bus.rom_addr_o !== 6'd0) begin n_fail++; $display("FAIL en_off_addr: got %0d want 0", bus.rom_addr_o); end
        bus.yumi_i = 1'b0;
        bus.en_i   = 1'b1;
        #1;
        n_cmp++; if (bus.v_o !== 1'b1 || bus.data_o !== c) begin n_fail++; $display("FAIL en_resume: got v=%b d=%h want v=1 d=%h", bus.v_o, bus.data_o, c); end
        bus.yumi_i = 1'b1;
        tick();
        bus.yumi_i = 1'b0;
        #1;
        n_cmp++; if (bus.rom_addr_o !== 6'd1) begin n_fail++; $display("FAIL en_advance: got %0d want 1", bus.rom_addr_o); end
    endtask

    task automatic test_reset_illegal();
        clear_rom();
        rom[0] = mk(4'd0, '0);
        rom[1] = mk(4'd9, '0);
        rom[2] = mk(4'd0, '0);
        rom[3] = mk(4'd3, '0);
        apply_reset();
        tick();
        n_cmp++; if (bus.rom_addr_o !== 6'd1 || bus.error_o !== 1'b0) begin n_fail++; $display("FAIL ill_nop: got a=%0d e=%b want a=1 e=0", bus.rom_addr_o, bus.error_o); end
        tick();
        n_cmp++; if (bus.rom_addr_o !== 6'd2 || bus.error_o !== 1'b1) begin n_fail++; $display("FAIL ill_op9: got a=%0d e=%b want a=2 e=1", bus.rom_addr_o, bus.error_o); end
        #2;
        reset_n_i = 1'b0;
        #1;
        n_cmp++; if (bus.rom_addr_o !== 6'd0 || bus.error_o !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got a=%0d e=%b want a=0 e=0", bus.rom_addr_o, bus.error_o); end
        reset_n_i = 1'b1;
        tick();
        n_cmp++; if (bus.rom_addr_o !== 6'd1) begin n_fail++; $display("FAIL restart_addr: got %0d want 1", bus.rom_addr_o); end
        tick();
        tick();
        tick();
        n_cmp++; if (bus.rom_addr_o !== 6'd3 || bus.error_o !== 1'b1 || bus.done_o !== 1'b1) begin
            n_fail++; $display("FAIL restart_end: got a=%0d e=%b d=%b want a=3 e=1 d=1", bus.rom_addr_o, bus.error_o, bus.done_o);
        end
    endtask

    task automatic test_wrap();
        logic [RW-1:0] p;
        p = 80'h7;
        for (int i = 0; i < 64; i++) rom[i] = mk(4'd0, '0);
        rom[0] = mk(4'd1, p);
        apply_reset();
        bus.yumi_i = 1'b1;
        tick();
        bus.yumi_i = 1'b0;
        for (int i = 0; i < 62; i++) tick();
        n_cmp++; if (bus.rom_addr_o !== 6'd63) begin n_fail++; $display("FAIL wrap_max: got %0d want 63", bus.rom_addr_o); end
        tick();
        n_cmp++; if (bus.rom_addr_o !== 6'd0 || bus.v_o !== 1'b1) begin n_fail++; $display("FAIL wrap_zero: got a=%0d v=%b want a=0 v=1", bus.rom_addr_o, bus.v_o); end
    endtask

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        reset_n_i  = 1'b1;
        bus.en_i   = 1'b1;
        bus.yumi_i = 1'b0;
        bus.v_i    = 1'b0;
        bus.data_i = '0;
        clear_rom();
        test_reset();
        test_loopback();
        test_mismatch();
        test_send_stall();
        test_wait();
        test_enable();
        test_reset_illegal();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
